rv32_wait_mem: RTL and testbench
================================

RV32_WAIT_MEM -- requirements
Module: rv32_wait_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of both ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; legal value 32 only, so there are 4 byte lanes.
REQ-003 SHALL have parameter MEM_DEPTH, default 1024, number of words in the array.
REQ-004 SHALL have parameter LATENCY, default 1, wait cycles between accept and access, legal range 0..7.
REQ-005 SHALL have ports `clk  in  1  clock`, the only clock; all logic is rising-edge.
REQ-006 SHALL have ports `reset  in  1  asynchronous, active-low reset`; 0 resets the block.
REQ-007 SHALL have instruction-port inputs `i_req_valid  in  1`, `i_addr  in  ADDR_WIDTH`, `i_resp_ready  in  1`.
REQ-008 SHALL have instruction-port outputs `i_req_ready  out  1`, `i_resp_valid  out  1`, `i_rdata  out  DATA_WIDTH`, `i_resp_err  out  1`.
REQ-009 SHALL have data-port inputs `d_req_valid  in  1`, `d_addr  in  ADDR_WIDTH`, `d_we  in  1`, `d_wstrb  in  4`, `d_wdata  in  DATA_WIDTH`, `d_resp_ready  in  1`.
REQ-010 SHALL have data-port outputs `d_req_ready  out  1`, `d_resp_valid  out  1`, `d_rdata  out  DATA_WIDTH`, `d_resp_err  out  1`.

Function
REQ-011 SHALL share one word array `mem[0:MEM_DEPTH-1]` between the ports; the instruction port is read-only.
REQ-012 SHALL run one independent FSM per port with states IDLE, WAIT and RESP; at most one request is outstanding per port.
REQ-013 SHALL drive req_ready=1 only in IDLE; a request is accepted on a cycle where req_valid and req_ready are both 1.
REQ-014 SHALL latch addr, and for the data port we, wstrb and wdata, on accept; later changes on the request inputs are ignored.
REQ-015 SHALL, on accept with LATENCY>0, enter WAIT with a 3-bit counter loaded with LATENCY-1 and decrement it each cycle.
REQ-016 SHALL perform the access on the WAIT cycle where the counter equals 0, then enter RESP.
REQ-017 SHALL, on accept with LATENCY=0, perform the access on the accept edge and enter RESP directly.
REQ-018 SHALL give a total latency of LATENCY+1 cycles from accept to first resp_valid=1.
REQ-019 SHALL, in RESP, hold resp_valid=1 with rdata and resp_err stable until resp_ready=1, then return to IDLE on that edge.
REQ-020 SHALL NOT accept a new request in the cycle a response is consumed; req_ready rises the following cycle.
REQ-021 SHALL, on a data read, return `mem[addr>>2]`.
REQ-022 SHALL, on a data write, update only the byte lanes k with wstrb[k]=1 and return rdata=0.
REQ-023 SHALL complete a write with wstrb=0 normally, with no array change and resp_err=0.
REQ-024 SHALL flag an error when addr[1:0]!=0 or (addr>>2)>=MEM_DEPTH: resp_err=1, rdata=0, no array write, same latency as a good access.
REQ-025 SHALL, when the instruction port reads a word in the same cycle the data port writes it, return the pre-write contents to the instruction port.
REQ-026 SHALL keep the two ports fully independent: no arbitration, and neither port stalls the other.
REQ-027 SHALL drive rdata=0 whenever resp_valid=0.

Reset
REQ-028 SHALL, while reset=0, put both FSMs in IDLE and force req_ready=0, resp_valid=0, rdata=0, resp_err=0 and counters=0.
REQ-029 SHALL raise req_ready=1 on the first rising clk edge after reset deasserts.
REQ-030 SHALL, on reset during WAIT, abandon the request; a write not yet performed never reaches the array.
REQ-031 SHALL NOT reset the array contents; they are initialised only by the bench (hierarchical write or $readmemh).

Verification
REQ-032 SHALL cover a read at LATENCY=1: preload mem[1]=0x00100093, i_addr=0x4 accepted at cycle t -> i_resp_valid=1 with i_rdata=0x00100093 at cycle t+2, i_resp_err=0.
REQ-033 SHALL cover a byte-strobe write: mem[2]=0x11223344, then d_we=1, d_addr=0x8, d_wstrb=4'b0101, d_wdata=0xAABBCCDD -> mem[2]=0x11BB33DD and the write response has d_rdata=0.
REQ-034 SHALL cover errors: d_addr=0x6 -> d_resp_err=1 with the array unchanged; i_addr=0x1000 at MEM_DEPTH=1024 -> i_resp_err=1 and i_rdata=0.
REQ-035 SHALL cover backpressure: hold d_resp_ready=0 for 5 cycles -> d_resp_valid stays 1, d_rdata stable and d_req_ready=0 throughout; one cycle after the consume, d_req_ready=1.
REQ-036 SHALL cover a same-word collision: mem[3]=0x00310113, then i-port read and d-port full write of 0x00000073 to 0xC issued in the same cycle -> i_rdata=0x00310113 and a subsequent read returns 0x00000073.
REQ-037 SHALL cover reset mid-WAIT at LATENCY=4: a write accepted, reset=0 two cycles later -> all outputs 0 immediately, the target word unchanged, and req_ready=1 after release.

Source files
------------

// File: rtl/rv32_wait_mem.sv
// rv32_wait_mem: one shared word array behind two independent request/response
// ports. The instruction port is read-only; the data port reads and writes with
// per-byte strobes. Each port has its own three-state controller. LATENCY wait
// cycles separate the accept from the array access.
//
// state | meaning
// IDLE  | no request outstanding; req_ready=1 once out of reset
// WAIT  | request latched; down-counter runs LATENCY-1..0, access at 0
// RESP  | response held stable until resp_ready
module rv32_wait_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_resp_ready,
    output logic                  i_req_ready,
    output logic                  i_resp_valid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_resp_err,
    input  logic                  d_req_valid,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_we,
    input  logic [3:0]            d_wstrb,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic                  d_resp_ready,
    output logic                  d_req_ready,
    output logic                  d_resp_valid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_resp_err
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [2:0] CNT_LOAD = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

    state_t i_state, i_state_nxt, d_state, d_state_nxt;
    logic [2:0] i_cnt, d_cnt;
    logic [ADDR_WIDTH-1:0] i_addr_q, d_addr_q;
    logic d_we_q;
    logic [3:0] d_wstrb_q;
    logic [DATA_WIDTH-1:0] d_wdata_q;
    logic [DATA_WIDTH-1:0] i_rdata_q, d_rdata_q;
    logic i_err_q, d_err_q;
    logic ready_en;

    logic i_accept, d_accept, i_access, d_access;
    logic [ADDR_WIDTH-1:0] i_acc_addr, d_acc_addr, i_word, d_word;
    logic [IDX_W-1:0] i_idx, d_idx;
    logic i_bad, d_bad, d_acc_we;
    logic [3:0] d_acc_wstrb;
    logic [DATA_WIDTH-1:0] d_acc_wdata;

    // With zero latency the access happens on the accept edge, straight from
    // the request inputs; otherwise it uses the values latched at accept.
    assign i_accept    = i_req_valid & i_req_ready;
    assign d_accept    = d_req_valid & d_req_ready;
    assign i_access    = (LATENCY == 0) ? i_accept : (i_state == WAIT && i_cnt == 3'd0);
    assign d_access    = (LATENCY == 0) ? d_accept : (d_state == WAIT && d_cnt == 3'd0);
    assign i_acc_addr  = (LATENCY == 0) ? i_addr : i_addr_q;
    assign d_acc_addr  = (LATENCY == 0) ? d_addr : d_addr_q;
    assign d_acc_we    = (LATENCY == 0) ? d_we : d_we_q;
    assign d_acc_wstrb = (LATENCY == 0) ? d_wstrb : d_wstrb_q;
    assign d_acc_wdata = (LATENCY == 0) ? d_wdata : d_wdata_q;
    assign i_word      = i_acc_addr >> 2;
    assign d_word      = d_acc_addr >> 2;
    assign i_idx       = i_word[IDX_W-1:0];
    assign d_idx       = d_word[IDX_W-1:0];
    assign i_bad       = (i_acc_addr[1:0] != 2'b00) || (i_word >= DEPTH_A);
    assign d_bad       = (d_acc_addr[1:0] != 2'b00) || (d_word >= DEPTH_A);

    // req_ready is held low during reset and rises on the first edge after it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // Array write from the data port; contents survive reset.
    always_ff @(posedge clk) begin
        if (d_access && d_acc_we && !d_bad) begin
            for (int k = 0; k < 4; k++) begin
                if (d_acc_wstrb[k]) mem[d_idx][8*k +: 8] <= d_acc_wdata[8*k +: 8];
            end
        end
    end

    // Instruction port state, request latch, wait counter and read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_state   <= IDLE;
            i_cnt     <= 3'd0;
            i_addr_q  <= '0;
            i_rdata_q <= '0;
            i_err_q   <= 1'b0;
        end else begin
            i_state <= i_state_nxt;
            if (i_accept) begin
                i_addr_q <= i_addr;
                i_cnt    <= CNT_LOAD;
            end else if (i_state == WAIT && i_cnt != 3'd0) begin
                i_cnt <= i_cnt - 3'd1;
            end
            if (i_access) begin
                i_err_q   <= i_bad;
                i_rdata_q <= i_bad ? '0 : mem[i_idx];
            end
        end
    end

    // Data port state, request latch, wait counter and read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_state   <= IDLE;
            d_cnt     <= 3'd0;
            d_addr_q  <= '0;
            d_we_q    <= 1'b0;
            d_wstrb_q <= 4'd0;
            d_wdata_q <= '0;
            d_rdata_q <= '0;
            d_err_q   <= 1'b0;
        end else begin
            d_state <= d_state_nxt;
            if (d_accept) begin
                d_addr_q  <= d_addr;
                d_we_q    <= d_we;
                d_wstrb_q <= d_wstrb;
                d_wdata_q <= d_wdata;
                d_cnt     <= CNT_LOAD;
            end else if (d_state == WAIT && d_cnt != 3'd0) begin
                d_cnt <= d_cnt - 3'd1;
            end
            if (d_access) begin
                d_err_q   <= d_bad;
                d_rdata_q <= (d_bad || d_acc_we) ? '0 : mem[d_idx];
            end
        end
    end

    // Instruction port next state and handshake outputs.
    always_comb begin
        i_state_nxt  = i_state;
        i_req_ready  = 1'b0;
        i_resp_valid = 1'b0;
        i_rdata      = '0;
        i_resp_err   = 1'b0;
        unique case (i_state)
            IDLE: begin
                i_req_ready = ready_en;
                if (i_accept) begin
                    if (LATENCY == 0) i_state_nxt = RESP;
                    else              i_state_nxt = WAIT;
                end
            end
            WAIT: if (i_cnt == 3'd0) i_state_nxt = RESP;
            RESP: begin
                i_resp_valid = 1'b1;
                i_rdata      = i_rdata_q;
                i_resp_err   = i_err_q;
                if (i_resp_ready) i_state_nxt = IDLE;
            end
            default: i_state_nxt = IDLE;
        endcase
    end

    // Data port next state and handshake outputs.
    always_comb begin
        d_state_nxt  = d_state;
        d_req_ready  = 1'b0;
        d_resp_valid = 1'b0;
        d_rdata      = '0;
        d_resp_err   = 1'b0;
        unique case (d_state)
            IDLE: begin
                d_req_ready = ready_en;
                if (d_accept) begin
                    if (LATENCY == 0) d_state_nxt = RESP;
                    else              d_state_nxt = WAIT;
                end
            end
            WAIT: if (d_cnt == 3'd0) d_state_nxt = RESP;
            RESP: begin
                d_resp_valid = 1'b1;
                d_rdata      = d_rdata_q;
                d_resp_err   = d_err_q;
                if (d_resp_ready) d_state_nxt = IDLE;
            end
            default: d_state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rv32_wait_mem.sv
// Bench for rv32_wait_mem: two instances (LATENCY 1 and 4) share all inputs;
// each is checked against its own copy of a word-array reference model.
module tb_rv32_wait_mem;
    localparam int LAT_A = 1;
    localparam int LAT_B = 4;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req_valid, i_resp_ready;
    logic [31:0] i_addr;
    logic        d_req_valid, d_we, d_resp_ready;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_wstrb;

    logic [1:0]       i_req_ready_v, i_resp_valid_v, i_resp_err_v;
    logic [1:0]       d_req_ready_v, d_resp_valid_v, d_resp_err_v;
    logic [1:0][31:0] i_rdata_v, d_rdata_v;

    logic [31:0] model_mem [2][0:DEPTH-1];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32_wait_mem #(.LATENCY(LAT_A)) dut_a (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .i_addr(i_addr), .i_resp_ready(i_resp_ready),
        .i_req_ready(i_req_ready_v[0]), .i_resp_valid(i_resp_valid_v[0]),
        .i_rdata(i_rdata_v[0]), .i_resp_err(i_resp_err_v[0]),
        .d_req_valid(d_req_valid), .d_addr(d_addr), .d_we(d_we), .d_wstrb(d_wstrb),
        .d_wdata(d_wdata), .d_resp_ready(d_resp_ready),
        .d_req_ready(d_req_ready_v[0]), .d_resp_valid(d_resp_valid_v[0]),
        .d_rdata(d_rdata_v[0]), .d_resp_err(d_resp_err_v[0])
    );

    rv32_wait_mem #(.LATENCY(LAT_B)) dut_b (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .i_addr(i_addr), .i_resp_ready(i_resp_ready),
        .i_req_ready(i_req_ready_v[1]), .i_resp_valid(i_resp_valid_v[1]),
        .i_rdata(i_rdata_v[1]), .i_resp_err(i_resp_err_v[1]),
        .d_req_valid(d_req_valid), .d_addr(d_addr), .d_we(d_we), .d_wstrb(d_wstrb),
        .d_wdata(d_wdata), .d_resp_ready(d_resp_ready),
        .d_req_ready(d_req_ready_v[1]), .d_resp_valid(d_resp_valid_v[1]),
        .d_rdata(d_rdata_v[1]), .d_resp_err(d_resp_err_v[1])
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT_A : LAT_B;
    endfunction

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= DEPTH);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int r;
        r = $urandom_range(0, 15);
        a = 32'($urandom_range(0, 31)) * 4;
        if (r == 0) a = a + 32'($urandom_range(1, 3));
        else if (r == 1) a = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
        else if (r == 2) a = 32'hFFFF_FFFC;
        else if (r == 3) a = 32'h0000_0FFC;
        return a;
    endfunction

    task automatic preload(input int idx, input logic [31:0] v);
        dut_a.mem[idx] = v;
        dut_b.mem[idx] = v;
        model_mem[0][idx] = v;
        model_mem[1][idx] = v;
    endtask

    // One transaction on either or both ports, accepted in the same cycle,
    // with responses consumed as soon as they appear.
    task automatic txn(input bit use_i, input logic [31:0] ia, input bit use_d,
                       input logic [31:0] da, input bit we, input logic [3:0] ws,
                       input logic [31:0] wd, input string tag);
        logic [31:0] exp_i [2];
        logic [31:0] exp_d [2];
        bit ei, ed;
        bit got_i [2];
        bit got_d [2];
        int cyc;
        ei = addr_bad(ia);
        ed = addr_bad(da);
        for (int k = 0; k < 2; k++) begin
            exp_i[k] = ei ? 32'd0 : model_mem[k][ia / 4];
            exp_d[k] = (ed || we) ? 32'd0 : model_mem[k][da / 4];
            if (use_d && we && !ed) begin
                for (int b = 0; b < 4; b++)
                    if (ws[b]) model_mem[k][da / 4][8*b +: 8] = wd[8*b +: 8];
            end
            got_i[k] = !use_i;
            got_d[k] = !use_d;
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({i_req_ready_v[k], d_req_ready_v[k]} !== 2'b11) begin
                errors++;
                $display("FAIL %s req_ready dut%0d: got i=%b d=%b, expected 1 1",
                         tag, k, i_req_ready_v[k], d_req_ready_v[k]);
            end
        end
        i_req_valid = use_i; i_addr = ia; i_resp_ready = 1'b1;
        d_req_valid = use_d; d_addr = da; d_we = we; d_wstrb = ws; d_wdata = wd;
        d_resp_ready = 1'b1;
        @(negedge clk);
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        i_addr = $urandom; d_addr = $urandom; d_we = 1'($urandom_range(0, 1));
        d_wstrb = 4'($urandom); d_wdata = $urandom;
        cyc = 1;
        while (!(got_i[0] && got_i[1] && got_d[0] && got_d[1]) && cyc <= 12) begin
            for (int k = 0; k < 2; k++) begin
                if (!got_i[k]) begin
                    checks++;
                    if (i_resp_valid_v[k]) begin
                        got_i[k] = 1'b1;
                        if (cyc != lat_of(k) + 1 || i_rdata_v[k] !== exp_i[k] ||
                            i_resp_err_v[k] !== ei || i_req_ready_v[k] !== 1'b0) begin
                            errors++;
                            $display("FAIL %s i_resp dut%0d: cyc=%0d rdata=%h err=%b rdy=%b, expected cyc=%0d rdata=%h err=%b rdy=0",
                                     tag, k, cyc, i_rdata_v[k], i_resp_err_v[k], i_req_ready_v[k],
                                     lat_of(k) + 1, exp_i[k], ei);
                        end
                    end else if (i_rdata_v[k] !== 32'd0 || i_resp_err_v[k] !== 1'b0 ||
                                 i_req_ready_v[k] !== 1'b0) begin
                        errors++;
                        $display("FAIL %s i_wait dut%0d: cyc=%0d rdata=%h err=%b rdy=%b, expected 0 0 0",
                                 tag, k, cyc, i_rdata_v[k], i_resp_err_v[k], i_req_ready_v[k]);
                    end
                end
                if (!got_d[k]) begin
                    checks++;
                    if (d_resp_valid_v[k]) begin
                        got_d[k] = 1'b1;
                        if (cyc != lat_of(k) + 1 || d_rdata_v[k] !== exp_d[k] ||
                            d_resp_err_v[k] !== ed || d_req_ready_v[k] !== 1'b0) begin
                            errors++;
                            $display("FAIL %s d_resp dut%0d: cyc=%0d rdata=%h err=%b rdy=%b, expected cyc=%0d rdata=%h err=%b rdy=0",
                                     tag, k, cyc, d_rdata_v[k], d_resp_err_v[k], d_req_ready_v[k],
                                     lat_of(k) + 1, exp_d[k], ed);
                        end
                    end else if (d_rdata_v[k] !== 32'd0 || d_resp_err_v[k] !== 1'b0 ||
                                 d_req_ready_v[k] !== 1'b0) begin
                        errors++;
                        $display("FAIL %s d_wait dut%0d: cyc=%0d rdata=%h err=%b rdy=%b, expected 0 0 0",
                                 tag, k, cyc, d_rdata_v[k], d_resp_err_v[k], d_req_ready_v[k]);
                    end
                end
            end
            if (!(got_i[0] && got_i[1] && got_d[0] && got_d[1])) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!(got_i[0] && got_i[1] && got_d[0] && got_d[1])) begin
            errors++;
            $display("FAIL %s timeout: got_i=%b%b got_d=%b%b, expected all responses",
                     tag, got_i[0], got_i[1], got_d[0], got_d[1]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({i_req_ready_v[k], i_resp_valid_v[k], i_resp_err_v[k], d_req_ready_v[k],
                 d_resp_valid_v[k], d_resp_err_v[k]} !== 6'd0 ||
                i_rdata_v[k] !== 32'd0 || d_rdata_v[k] !== 32'd0) begin
                errors++;
                $display("FAIL %s dut%0d: flags=%b%b%b%b%b%b i_rdata=%h d_rdata=%h, expected all 0",
                         tag, k, i_req_ready_v[k], i_resp_valid_v[k], i_resp_err_v[k],
                         d_req_ready_v[k], d_resp_valid_v[k], d_resp_err_v[k],
                         i_rdata_v[k], d_rdata_v[k]);
            end
        end
    endtask

    task automatic check_ready(input logic [1:0] exp, input string tag);
        checks++;
        if (i_req_ready_v !== exp || d_req_ready_v !== exp) begin
            errors++;
            $display("FAIL %s: i_req_ready=%b d_req_ready=%b, expected %b",
                     tag, i_req_ready_v, d_req_ready_v, exp);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        check_all_zero("reset_outputs");
        reset = 1'b1;
        #1;
        check_ready(2'b00, "ready_before_edge");
        @(negedge clk);
        check_ready(2'b11, "ready_after_edge");
    endtask

    task automatic test_read();
        txn(1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, "read_w1");
        txn(1'b0, 32'h0, 1'b1, 32'h4, 1'b0, 4'h0, 32'h0, "dread_w1");
    endtask

    task automatic test_byte_write();
        txn(1'b0, 32'h0, 1'b1, 32'h8, 1'b1, 4'b0101, 32'hAABBCCDD, "bytewr");
        txn(1'b1, 32'h8, 1'b1, 32'h8, 1'b0, 4'h0, 32'h0, "bytewr_rb");
        txn(1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 4'b0000, 32'h12345678, "wstrb0");
        txn(1'b0, 32'h0, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0, "wstrb0_rb");
    endtask

    task automatic test_errors();
        txn(1'b0, 32'h0, 1'b1, 32'h6, 1'b0, 4'h0, 32'h0, "err_misal_rd");
        txn(1'b0, 32'h0, 1'b1, 32'h6, 1'b1, 4'hF, 32'hFFFFFFFF, "err_misal_wr");
        txn(1'b1, 32'h1000, 1'b1, 32'h1000, 1'b1, 4'hF, 32'h5A5A5A5A, "err_range");
        txn(1'b1, 32'h4, 1'b1, 32'h0FFC, 1'b0, 4'h0, 32'h0, "err_rb");
    endtask

    task automatic test_backpressure();
        logic [31:0] exp [2];
        int n;
        @(negedge clk);
        exp[0] = model_mem[0][7];
        exp[1] = model_mem[1][7];
        d_resp_ready = 1'b0;
        d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h1C;
        @(negedge clk);
        d_req_valid = 1'b0; d_addr = $urandom;
        n = 0;
        while (d_resp_valid_v !== 2'b11 && n < 12) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (d_resp_valid_v !== 2'b11) begin
            errors++;
            $display("FAIL bp_wait: d_resp_valid=%b, expected 11", d_resp_valid_v);
        end
        repeat (5) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (d_resp_valid_v[k] !== 1'b1 || d_rdata_v[k] !== exp[k] ||
                    d_req_ready_v[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_hold dut%0d: valid=%b rdata=%h rdy=%b, expected 1 %h 0",
                             k, d_resp_valid_v[k], d_rdata_v[k], d_req_ready_v[k], exp[k]);
                end
            end
            @(negedge clk);
        end
        d_resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (d_resp_valid_v !== 2'b00 || d_req_ready_v !== 2'b11) begin
            errors++;
            $display("FAIL bp_release: valid=%b rdy=%b, expected 00 11",
                     d_resp_valid_v, d_req_ready_v);
        end
    endtask

    task automatic test_collision();
        txn(1'b1, 32'hC, 1'b1, 32'hC, 1'b1, 4'hF, 32'h00000073, "collision");
        txn(1'b1, 32'hC, 1'b1, 32'hC, 1'b0, 4'h0, 32'h0, "collision_rb");
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            bit ui, ud;
            ui = ($urandom_range(0, 3) != 0);
            ud = ($urandom_range(0, 3) != 0) || !ui;
            txn(ui, rand_addr(), ud, rand_addr(), 1'($urandom_range(0, 1)),
                4'($urandom), $urandom, "random");
        end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        d_req_valid = 1'b1; d_we = 1'b1; d_addr = 32'h24; d_wstrb = 4'hF;
        d_wdata = 32'hDEADBEEF; d_resp_ready = 1'b1;
        @(negedge clk);
        d_req_valid = 1'b0; d_we = 1'b0;
        // the LATENCY=1 instance has already written before the reset lands
        model_mem[0][9] = 32'hDEADBEEF;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all_zero("reset_mid_wait");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_ready(2'b00, "rmw_ready_before_edge");
        @(negedge clk);
        check_ready(2'b11, "rmw_ready_after_edge");
        txn(1'b1, 32'h24, 1'b1, 32'h24, 1'b0, 4'h0, 32'h0, "rmw_rb");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        i_req_valid = 1'b0; i_addr = 32'h0; i_resp_ready = 1'b1;
        d_req_valid = 1'b0; d_addr = 32'h0; d_we = 1'b0; d_wstrb = 4'h0;
        d_wdata = 32'h0; d_resp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) preload(i, $urandom);
        preload(1, 32'h00100093);
        preload(2, 32'h11223344);
        preload(3, 32'h00310113);
        preload(9, 32'h0BADF00D);
        #1 reset = 1'b0;
        test_reset();
        test_read();
        test_byte_write();
        test_errors();
        test_backpressure();
        test_collision();
        test_random();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
